// File: rtl/can_filter_bank.sv
// CAN acceptance filter bank: NUM_FILTERS code/mask filters feeding an accepted-frame FIFO.
// Optional feature macro CAN_FILTER_HIT_CNT_EN adds per-filter saturating hit counters.
module can_filter_bank #(
  parameter int  NUM_FILTERS = 8,
  parameter int  FIFO_DEPTH  = 4,
  parameter int  CNT_W       = 16,
  localparam int IDX_W       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [28:0]      id_in,
  input  logic             ide_in,
  input  logic             id_valid_in,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [28:0]      cfg_code,
  input  logic [28:0]      cfg_mask,
  input  logic             cfg_en,
  input  logic             cfg_ide,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [28:0]      out_id,
  output logic             out_ide,
  output logic [IDX_W-1:0] out_hit,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic [IDX_W-1:0] cnt_idx,
  output logic [CNT_W-1:0] cnt_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Filter configuration registers
  logic [28:0]            code_r [NUM_FILTERS];
  logic [28:0]            mask_r [NUM_FILTERS];
  logic [NUM_FILTERS-1:0] en_r;
  logic [NUM_FILTERS-1:0] ide_r;
  logic                   cfg_in_range;

  assign cfg_in_range = (32'(cfg_idx) < NUM_FILTERS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_r  <= '0;
      ide_r <= '0;
      for (int i = 0; i < NUM_FILTERS; i++) begin
        code_r[i] <= '0;
        mask_r[i] <= '0;
      end
    end else if (cfg_we && cfg_in_range) begin
      en_r[cfg_idx]   <= cfg_en;
      ide_r[cfg_idx]  <= cfg_ide;
      code_r[cfg_idx] <= cfg_code;
      mask_r[cfg_idx] <= cfg_mask;
    end
  end

  // Stage p0: compare incoming ID against every filter, lowest index wins
  logic [28:0]            id_p0;
  logic [NUM_FILTERS-1:0] match_p0;
  logic                   match_any_p0;
  logic [IDX_W-1:0]       match_idx_p0;
  logic                   vld_p0;

  assign id_p0 = ide_in ? id_in : {18'b0, id_in[10:0]};

  always_comb begin
    match_p0 = '0;
    for (int i = 0; i < NUM_FILTERS; i++) begin
      match_p0[i] = en_r[i] && (ide_r[i] == ide_in) &&
                    ((id_p0 & mask_r[i]) == (code_r[i] & mask_r[i]));
    end
  end

  always_comb begin
    match_any_p0 = 1'b0;
    match_idx_p0 = '0;
    for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
      if (match_p0[i]) begin
        match_any_p0 = 1'b1;
        match_idx_p0 = IDX_W'(i);
      end
    end
  end

  assign vld_p0 = id_valid_in && match_any_p0;

  // Stage p1: registered match result, written to the FIFO at the end of this cycle
  logic             vld_p1;
  logic [28:0]      id_p1;
  logic             ide_p1;
  logic [IDX_W-1:0] hit_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      id_p1  <= id_p0;
      ide_p1 <= ide_in;
      hit_p1 <= match_idx_p0;
    end
  end

  // Accepted-frame FIFO
  logic [28:0]      fifo_id  [FIFO_DEPTH];
  logic             fifo_ide [FIFO_DEPTH];
  logic [IDX_W-1:0] fifo_hit [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             push_drop;

  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop       = !empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
  assign push_ok   = vld_p1 && (!full || pop);
  assign push_drop = vld_p1 && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (push_drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_id[wr_ptr]  <= id_p1;
      fifo_ide[wr_ptr] <= ide_p1;
      fifo_hit[wr_ptr] <= hit_p1;
    end
  end

  assign out_valid = !empty;
  assign out_id    = empty ? '0 : fifo_id[rd_ptr];
  assign out_ide   = empty ? 1'b0 : fifo_ide[rd_ptr];
  assign out_hit   = empty ? '0 : fifo_hit[rd_ptr];

`ifdef CAN_FILTER_HIT_CNT_EN
  logic [CNT_W-1:0] hit_cnt [NUM_FILTERS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FILTERS; i++) hit_cnt[i] <= '0;
    end else if (push_ok) begin
      hit_cnt[hit_p1] <= sat_inc(hit_cnt[hit_p1]);
    end
  end

  assign cnt_data = (32'(cnt_idx) < NUM_FILTERS) ? hit_cnt[cnt_idx] : '0;
`else
  logic unused_cnt_idx;
  assign unused_cnt_idx = ^cnt_idx;
  assign cnt_data       = '0;
`endif

endmodule

// File: tb/tb_can_filter_bank.sv
// Directed bench for can_filter_bank: filter matching, priority, FIFO behaviour, counters, reset.
module tb_can_filter_bank;

  logic        clk;
  logic        rst_n;
  logic [28:0] id_in;
  logic        ide_in;
  logic        id_valid_in;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [28:0] cfg_code;
  logic [28:0] cfg_mask;
  logic        cfg_en;
  logic        cfg_ide;
  logic        out_valid;
  logic        out_ready;
  logic [28:0] out_id;
  logic        out_ide;
  logic [2:0]  out_hit;
  logic [15:0] drop_cnt;
  logic [2:0]  cnt_idx;
  logic [15:0] cnt_data;

  int n_pass  = 0;
  int n_total = 0;

  can_filter_bank #(.NUM_FILTERS(8), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_in(id_in), .ide_in(ide_in), .id_valid_in(id_valid_in),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_code(cfg_code), .cfg_mask(cfg_mask),
    .cfg_en(cfg_en), .cfg_ide(cfg_ide), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_ide(out_ide), .out_hit(out_hit), .drop_cnt(drop_cnt),
    .cnt_idx(cnt_idx), .cnt_data(cnt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_id(input logic [28:0] id, input logic ide);
    id_in = id; ide_in = ide; id_valid_in = 1'b1;
    tick(1);
    id_valid_in = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [28:0] code,
                           input logic [28:0] mask, input logic en, input logic ide);
    cfg_we = 1'b1; cfg_idx = idx; cfg_code = code; cfg_mask = mask; cfg_en = en; cfg_ide = ide;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_id !== 29'h0) $display("FAIL rst_out_id: got %0h want 0", out_id); else n_pass++;
    n_total++; if (out_ide !== 1'b0) $display("FAIL rst_out_ide: got %0b want 0", out_ide); else n_pass++;
    n_total++; if (out_hit !== 3'd0) $display("FAIL rst_out_hit: got %0d want 0", out_hit); else n_pass++;
    n_total++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); else n_pass++;
    n_total++; if (cnt_data !== 16'd0) $display("FAIL rst_cnt_data: got %0d want 0", cnt_data); else n_pass++;
  endtask

  task automatic test_basic();
    cfg_write(3'd0, 29'h123, 29'h7FF, 1'b1, 1'b0);
    send_id(29'h123, 1'b0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_n1_valid: got %0b want 0", out_valid); else n_pass++;
    tick(1);
    n_total++; if (out_valid !== 1'b1) $display("FAIL basic_n2_valid: got %0b want 1", out_valid); else n_pass++;
    n_total++; if (out_id !== 29'h123) $display("FAIL basic_id: got %0h want 123", out_id); else n_pass++;
    n_total++; if (out_ide !== 1'b0) $display("FAIL basic_ide: got %0b want 0", out_ide); else n_pass++;
    n_total++; if (out_hit !== 3'd0) $display("FAIL basic_hit: got %0d want 0", out_hit); else n_pass++;
    tick(2);
    n_total++; if (out_id !== 29'h123) $display("FAIL basic_hold_id: got %0h want 123", out_id); else n_pass++;
    pop_one();
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_pop: got %0b want 0", out_valid); else n_pass++;
    send_id(29'h124, 1'b0);
    tick(3);
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_reject: got %0b want 0", out_valid); else n_pass++;
    // Standard frame: upper identifier bits must not affect matching
    send_id(29'h1FFFF123, 1'b0);
    tick(1);
    n_total++; if (out_valid !== 1'b1) $display("FAIL basic_upper_valid: got %0b want 1", out_valid); else n_pass++;
    n_total++; if (out_hit !== 3'd0) $display("FAIL basic_upper_hit: got %0d want 0", out_hit); else n_pass++;
    pop_one();
  endtask

  task automatic test_priority();
    cfg_write(3'd1, 29'h1ABCDEF0, 29'h1FFFFFFF, 1'b1, 1'b1);
    cfg_write(3'd3, 29'h1ABCDE00, 29'h1FFFFF00, 1'b1, 1'b1);
    send_id(29'h1ABCDEF0, 1'b1);
    tick(1);
    n_total++; if (out_valid !== 1'b1) $display("FAIL prio_valid: got %0b want 1", out_valid); else n_pass++;
    n_total++; if (out_hit !== 3'd1) $display("FAIL prio_hit: got %0d want 1", out_hit); else n_pass++;
    n_total++; if (out_id !== 29'h1ABCDEF0) $display("FAIL prio_id: got %0h want 1abcdef0", out_id); else n_pass++;
    n_total++; if (out_ide !== 1'b1) $display("FAIL prio_ide: got %0b want 1", out_ide); else n_pass++;
    pop_one();
    send_id(29'h1ABCDE55, 1'b1);
    tick(1);
    n_total++; if (out_hit !== 3'd3) $display("FAIL prio_hit3: got %0d want 3", out_hit); else n_pass++;
    pop_one();
  endtask

  task automatic test_ide();
    cfg_write(3'd0, 29'h123, 29'h7FF, 1'b0, 1'b0);
    cfg_write(3'd4, 29'h123, 29'h1FFFFFFF, 1'b1, 1'b1);
    send_id(29'h123, 1'b0);
    tick(3);
    n_total++; if (out_valid !== 1'b0) $display("FAIL ide_std_reject: got %0b want 0", out_valid); else n_pass++;
    send_id(29'h123, 1'b1);
    tick(1);
    n_total++; if (out_valid !== 1'b1) $display("FAIL ide_ext_valid: got %0b want 1", out_valid); else n_pass++;
    n_total++; if (out_hit !== 3'd4) $display("FAIL ide_ext_hit: got %0d want 4", out_hit); else n_pass++;
    pop_one();
  endtask

  task automatic test_cfg_timing();
    // Configuration write and ID in the same cycle: the ID sees the old (disabled) filter
    cfg_we = 1'b1; cfg_idx = 3'd6; cfg_code = 29'h555; cfg_mask = 29'h7FF; cfg_en = 1'b1; cfg_ide = 1'b0;
    id_in = 29'h555; ide_in = 1'b0; id_valid_in = 1'b1;
    tick(1);
    cfg_we = 1'b0; id_valid_in = 1'b0;
    tick(3);
    n_total++; if (out_valid !== 1'b0) $display("FAIL cfg_same_cycle: got %0b want 0", out_valid); else n_pass++;
    send_id(29'h555, 1'b0);
    tick(1);
    n_total++; if (out_valid !== 1'b1) $display("FAIL cfg_next_valid: got %0b want 1", out_valid); else n_pass++;
    n_total++; if (out_hit !== 3'd6) $display("FAIL cfg_next_hit: got %0d want 6", out_hit); else n_pass++;
    pop_one();
  endtask

  task automatic test_fifo_full();
    logic [28:0] exp_ids [4];
    exp_ids = '{29'h11, 29'h12, 29'h13, 29'h16};
    cfg_write(3'd5, 29'h0, 29'h0, 1'b1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_id(29'h10 + 29'(i), 1'b0);
    tick(2);
    n_total++; if (drop_cnt !== 16'd2) $display("FAIL fifo_drop: got %0d want 2", drop_cnt); else n_pass++;
    n_total++; if (out_id !== 29'h10) $display("FAIL fifo_head: got %0h want 10", out_id); else n_pass++;
    id_in = 29'h16; ide_in = 1'b0; id_valid_in = 1'b1;
    tick(1);
    id_valid_in = 1'b0;
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    n_total++; if (drop_cnt !== 16'd2) $display("FAIL fifo_full_pushpop_drop: got %0d want 2", drop_cnt); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (out_valid !== 1'b1) $display("FAIL fifo_drain_valid%0d: got %0b want 1", i, out_valid); else n_pass++;
      n_total++; if (out_id !== exp_ids[i]) $display("FAIL fifo_order%0d: got %0h want %0h", i, out_id, exp_ids[i]); else n_pass++;
      pop_one();
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL fifo_empty: got %0b want 0", out_valid); else n_pass++;
    pop_one();
    n_total++; if (out_valid !== 1'b0) $display("FAIL fifo_pop_empty: got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_push_pop_empty();
    out_ready = 1'b1;
    send_id(29'h123, 1'b1);
    n_total++; if (out_valid !== 1'b0) $display("FAIL ppe_n1: got %0b want 0", out_valid); else n_pass++;
    tick(1);
    n_total++; if (out_valid !== 1'b1) $display("FAIL ppe_n2: got %0b want 1", out_valid); else n_pass++;
    n_total++; if (out_hit !== 3'd4) $display("FAIL ppe_hit: got %0d want 4", out_hit); else n_pass++;
    tick(1);
    n_total++; if (out_valid !== 1'b0) $display("FAIL ppe_n3: got %0b want 0", out_valid); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_hit_cnt();
    logic [15:0] exp2, exp4, exp5;
`ifdef CAN_FILTER_HIT_CNT_EN
    exp2 = 16'd3; exp4 = 16'd2; exp5 = 16'd5;
`else
    exp2 = 16'd0; exp4 = 16'd0; exp5 = 16'd0;
`endif
    cfg_write(3'd2, 29'h0ABCDE, 29'h1FFFFFFF, 1'b1, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_id(29'h0ABCDE, 1'b1);
    tick(3);
    out_ready = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL hit_drained: got %0b want 0", out_valid); else n_pass++;
    cnt_idx = 3'd2; #1;
    n_total++; if (cnt_data !== exp2) $display("FAIL hit_cnt2: got %0d want %0d", cnt_data, exp2); else n_pass++;
    cnt_idx = 3'd4; #1;
    n_total++; if (cnt_data !== exp4) $display("FAIL hit_cnt4: got %0d want %0d", cnt_data, exp4); else n_pass++;
    cnt_idx = 3'd5; #1;
    n_total++; if (cnt_data !== exp5) $display("FAIL hit_cnt5: got %0d want %0d", cnt_data, exp5); else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_id(29'h31 + 29'(i), 1'b0);
    tick(2);
    n_total++; if (out_valid !== 1'b1) $display("FAIL rmid_pre_valid: got %0b want 1", out_valid); else n_pass++;
    n_total++; if (drop_cnt !== 16'd2) $display("FAIL rmid_pre_drop: got %0d want 2", drop_cnt); else n_pass++;
    #2 rst_n = 1'b0;
    #2;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (drop_cnt !== 16'd0) $display("FAIL rmid_drop: got %0d want 0", drop_cnt); else n_pass++;
    n_total++; if (out_id !== 29'h0) $display("FAIL rmid_id: got %0h want 0", out_id); else n_pass++;
    n_total++; if (cnt_data !== 16'd0) $display("FAIL rmid_cnt: got %0d want 0", cnt_data); else n_pass++;
    tick(1);
    rst_n = 1'b1;
    send_id(29'h10, 1'b0);
    tick(3);
    n_total++; if (out_valid !== 1'b0) $display("FAIL rmid_disabled: got %0b want 0", out_valid); else n_pass++;
    cfg_write(3'd5, 29'h0, 29'h0, 1'b1, 1'b0);
    send_id(29'h20, 1'b0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL rmid_n1: got %0b want 0", out_valid); else n_pass++;
    tick(1);
    n_total++; if (out_valid !== 1'b1) $display("FAIL rmid_n2: got %0b want 1", out_valid); else n_pass++;
    n_total++; if (out_id !== 29'h20) $display("FAIL rmid_id2: got %0h want 20", out_id); else n_pass++;
    n_total++; if (out_hit !== 3'd5) $display("FAIL rmid_hit: got %0d want 5", out_hit); else n_pass++;
    pop_one();
  endtask

  initial begin
    rst_n = 1'b0; id_in = '0; ide_in = 1'b0; id_valid_in = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_code = '0; cfg_mask = '0; cfg_en = 1'b0; cfg_ide = 1'b0;
    out_ready = 1'b0; cnt_idx = '0;
    test_reset();
    test_basic();
    test_priority();
    test_ide();
    test_cfg_timing();
    test_fifo_full();
    test_push_pop_empty();
    test_hit_cnt();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
